// File: rtl/bp_me_pkg.sv
// Shared types and constants for the bp_me memory-command arbiter.
// The optional statistics build (BP_ME_MEM_ARB_STATS_EN) uses the stat struct and sat_inc.
package bp_me_pkg;

    localparam int unsigned bp_me_mem_arb_max_req_gp = 8;

    typedef struct packed {
        logic [31:0] grants;
        logic [31:0] stalls;
    } bp_me_mem_arb_stat_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bp_me_mem_arb_tag_fifo.sv
// In-order FIFO of requester IDs for commands awaiting a response.
// It drives full, empty and head data. Push is ignored while full and pop is ignored while empty.
module bp_me_mem_arb_tag_fifo #(
    parameter int unsigned depth_p = 4,
    parameter int unsigned width_p = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [width_p-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [width_p-1:0] head_data
);

    localparam int unsigned ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int unsigned cnt_w = $clog2(depth_p + 1);

    logic [width_p-1:0] mem [depth_p];
    logic [ptr_w-1:0]   wptr_q, rptr_q;
    logic [cnt_w-1:0]   count_q;
    logic               do_push, do_pop;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == cnt_w'(depth_p));
    assign empty     = (count_q == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= push_data;
    end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin sharing of one bp_mem command/response port among num_req_p requesters.
// Responses are routed in order via a tag FIFO; BP_ME_MEM_ARB_STATS_EN adds grant and stall counters.
module bp_me_mem_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter int unsigned num_req_p     = 2,
    parameter int unsigned msg_width_p   = 8,
    parameter int unsigned outstanding_p = 4,
    localparam int unsigned lg_req_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             req_mem_cmd_v_i,
    input  logic [num_req_p*msg_width_p-1:0] req_mem_cmd_i,
    output logic [num_req_p-1:0]             req_mem_cmd_ready_o,
    output logic [num_req_p-1:0]             req_mem_resp_v_o,
    output logic [msg_width_p-1:0]           req_mem_resp_o,
    input  logic [num_req_p-1:0]             req_mem_resp_yumi_i,
    output logic                             mem_cmd_v_o,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    input  logic                             mem_cmd_ready_i,
    input  logic                             mem_resp_v_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    output logic                             mem_resp_yumi_o,
    output logic                             error_o
`ifdef BP_ME_MEM_ARB_STATS_EN
    ,output logic [num_req_p*64-1:0]         stat_o
`endif
);

    logic [lg_req_lp-1:0] rr_q, rr_d, winner, cand, head;
    logic [num_req_p-1:0] head_mask;
    logic                 fifo_full, fifo_empty, any_v, accept, yumi_err;

    // Scan downward so the requester nearest to rr_q is written last and wins.
    always_comb begin
        winner = rr_q;
        cand   = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            cand = lg_req_lp'((int'(rr_q) + k) % num_req_p);
            if (req_mem_cmd_v_i[cand]) winner = cand;
        end
    end

    assign any_v       = |req_mem_cmd_v_i;
    assign mem_cmd_v_o = any_v & ~fifo_full;
    assign mem_cmd_o   = req_mem_cmd_i[int'(winner)*msg_width_p +: msg_width_p];
    assign accept      = mem_cmd_v_o & mem_cmd_ready_i;

    always_comb begin
        req_mem_cmd_ready_o         = '0;
        req_mem_cmd_ready_o[winner] = mem_cmd_ready_i & ~fifo_full;
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) rr_d = (winner == lg_req_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;
    end

    assign req_mem_resp_o = mem_resp_i;

    always_comb begin
        req_mem_resp_v_o       = '0;
        req_mem_resp_v_o[head] = mem_resp_v_i & ~fifo_empty;
        head_mask              = '0;
        head_mask[head]        = ~fifo_empty;
    end

    assign mem_resp_yumi_o = req_mem_resp_yumi_i[head] & req_mem_resp_v_o[head];
    assign yumi_err        = |(req_mem_resp_yumi_i & ~head_mask);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_q    <= '0;
            error_o <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            error_o <= error_o | yumi_err | (mem_resp_v_i & fifo_empty);
        end
    end

    bp_me_mem_arb_tag_fifo #(
        .depth_p (outstanding_p),
        .width_p (lg_req_lp)
    ) u_tag_fifo (
        .clk       (clk_i),
        .reset_n   (reset_n_i),
        .push      (accept),
        .push_data (winner),
        .pop       (mem_resp_yumi_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head)
    );

`ifdef BP_ME_MEM_ARB_STATS_EN
    bp_me_mem_arb_stat_s stat_q [num_req_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_req_p; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (req_mem_cmd_v_i[i] & req_mem_cmd_ready_o[i])
                    stat_q[i].grants <= sat_inc(stat_q[i].grants);
                if (req_mem_cmd_v_i[i] & ~req_mem_cmd_ready_o[i])
                    stat_q[i].stalls <= sat_inc(stat_q[i].stalls);
            end
        end
    end

    for (genvar g = 0; g < num_req_p; g++) begin : g_stat
        assign stat_o[g*64 +: 64] = stat_q[g];
    end

    final begin
        for (int i = 0; i < num_req_p; i++)
            $display("mem_cmd_arbiter req %0d: grants=%0d stalls=%0d",
                     i, stat_q[i].grants, stat_q[i].stalls);
    end
`endif

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
Name: bp_me_mem_cmd_arbiter

Overview:
- Shares one bp_mem command/response port among num_req_p memory requesters, e.g. a dcache wrapper and an icache wrapper in the BE/FE cache testbenches, or a UCE plus an I/O master.
- Commands are granted round-robin and forwarded unchanged.
- The requester ID of each forwarded command is pushed into an in-order tag FIFO. Each response is routed to the requester at the FIFO head.
- The downstream memory returns responses in command order.

Parameters:
- num_req_p, 2, number of upstream requesters (≥2).
- msg_width_p, 8, width of cce_mem_msg. Set from cce_mem_msg_width_lp in the instantiating bench.
- outstanding_p, 4, maximum commands in flight; also the tag FIFO depth (≥1).
- lg_req_lp (local), `BSG_SAFE_CLOG2(num_req_p), requester ID width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_mem_cmd_v_i  in  num_req_p  per-requester command valid.
- req_mem_cmd_i  in  num_req_p*msg_width_p  per-requester command; requester i occupies slice i.
- req_mem_cmd_ready_o  out  num_req_p  per-requester command ready.
- req_mem_resp_v_o  out  num_req_p  per-requester response valid.
- req_mem_resp_o  out  msg_width_p  response, broadcast to all requesters.
- req_mem_resp_yumi_i  in  num_req_p  per-requester response yumi.
- mem_cmd_v_o  out  1  downstream command valid.
- mem_cmd_o  out  msg_width_p  downstream command.
- mem_cmd_ready_i  in  1  downstream command ready.
- mem_resp_v_i  in  1  downstream response valid.
- mem_resp_i  in  msg_width_p  downstream response.
- mem_resp_yumi_o  out  1  downstream response yumi.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - round-robin pointer rr_r=0; tag FIFO empty; error_o=0.
  - All outputs are 0, because all valids/readies derive from the empty FIFO and from inputs.
- Command path (combinational, zero latency):
  - Winner w = first i with req_mem_cmd_v_i[i]=1, searching from rr_r upward modulo num_req_p.
  - mem_cmd_v_o = any valid & ~fifo_full.
  - mem_cmd_o = slice w.
  - req_mem_cmd_ready_o[i] = (i==w) & mem_cmd_ready_i & ~fifo_full.
- Command accept:
  - Accept when mem_cmd_v_o & mem_cmd_ready_i.
  - On accept: push w into the tag FIFO; rr_r <= (w+1) mod num_req_p.
  - rr_r holds when no command is accepted.
- Full FIFO: when fifo_full, no grant is issued, even if a pop occurs in the same cycle. No bypass.
- Response path:
  - req_mem_resp_o = mem_resp_i.
  - req_mem_resp_v_o[head] = mem_resp_v_i & ~fifo_empty; all other bits 0.
  - mem_resp_yumi_o = req_mem_resp_yumi_i[head] & req_mem_resp_v_o[head].
  - The tag FIFO pops on mem_resp_yumi_o.
- Same-cycle events: push and pop in one cycle (FIFO not full) leave the occupancy unchanged.
- Yumi from a non-head requester is ignored and sets error_o.
- Response with empty FIFO: mem_resp_v_i=1 while fifo_empty sets error_o, and mem_resp_yumi_o stays 0. error_o clears only on reset.
- Occupancy counter: width $clog2(outstanding_p+1); it never wraps.

Optional Feature:
- Macro: BP_ME_MEM_ARB_STATS_EN.
- When defined:
  - Per-requester 32-bit saturating counters for grants issued and stall cycles. A stall cycle is valid=1 with ready_o=0.
  - Counters are exposed on an extra output stat_o (num_req_p*64 bits) and reset to 0.
  - A final-block $display prints them.
- When undefined: the counters, the stat_o port and the $display are absent. Behaviour is otherwise identical.

Decomposition:
- bp_me_pkg gains:
  - constant bp_me_mem_arb_max_req_gp = 8;
  - typedef bp_me_mem_arb_stat_s {grants, stalls}.
- One sub-module, bp_me_mem_arb_tag_fifo: depth outstanding_p, width lg_req_lp, async active-low reset. It outputs full, empty and head data.

Test Plan:
- Single requester: req0 sends cmd A and memory returns resp A → req_mem_resp_v_o=2'b01, one yumi, FIFO empty after.
- Contention: both requesters continuously valid for 4 accepts starting rr_r=0 → grant order 0,1,0,1; responses routed 0,1,0,1.
- Full FIFO (outstanding_p=4): 4 cmds accepted with mem_resp_v_i held 0 → 5th cmd sees ready_o=0. A pop in the next cycle leaves ready=0 that cycle (no bypass); the grant resumes the cycle after.
- Backpressure: mem_cmd_ready_i=0 for 10 cycles → no push, rr_r unchanged, req_mem_cmd_ready_o=0.
- Spurious response: mem_resp_v_i=1 with FIFO empty → mem_resp_yumi_o=0, error_o=1 next cycle and held.
- Reset mid-operation: assert reset_n_i with 3 commands outstanding → FIFO empty, rr_r=0, error_o=0 immediately (asynchronous). Normal operation resumes after deassertion.
